rx_frame_parser: RTL

- Receive-side stage directly downstream of rgmii_rx. Consumes its byte stream (data, data_valid, data_enable, data_error).
- Strips preamble/SFD and the Ethernet header, extracts the video segment header (segment_num, txid, aux), and streams the pixel payload with a byte index for the RX frame-buffer writer.
- Checks the FCS, then marks each frame as good or bad.
- Input arrives already in the clk125MHz domain; the CDC FIFO sits upstream.

---
 rtl/rx_frame_parser_if.sv | 23 ++
 rtl/rx_frame_parser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_parser_if.sv
// -----------------------------------------------------------------------------
// rx_frame_parser_if
//   Byte stream from rgmii_rx into rx_frame_parser, already in the
//   clk125MHz domain.
//
//   in_data    8  received byte
//   in_valid   1  high for the whole frame including preamble; falling edge
//                 ends the frame
//   in_enable  1  byte strobe; a byte counts only with in_valid also high
//   in_error   1  PHY error flag, qualified by the byte strobe
//
//   master : the byte source (rgmii_rx side)
//   slave  : the parser
// -----------------------------------------------------------------------------
interface rx_frame_parser_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_enable;
  logic       in_error;

  modport master (output in_data, in_valid, in_enable, in_error);
  modport slave  (input  in_data, in_valid, in_enable, in_error);
endinterface

// File: rtl/rx_frame_parser.sv
// -----------------------------------------------------------------------------
// rx_frame_parser
//   Strips preamble/SFD and the Ethernet header from the rgmii_rx byte stream,
//   latches the video segment header (segment_num, txid, aux), streams the
//   pixel payload with a byte index, and checks the FCS to classify each frame
//   as good or bad.
//
//   Optional build macro MAC_FILTER_EN: when defined, a frame whose dst MAC is
//   neither MY_MAC nor broadcast is dropped silently (no ok/bad pulse, no
//   counter change). When undefined, the dst MAC is not checked.
//
// Ports
//   clk125MHz    clock, rising edge
//   rstb         asynchronous active-low reset
//   rx           byte stream in (rx_frame_parser_if.slave)
//   out_data     payload byte
//   out_valid    one-cycle strobe per payload byte
//   out_addr     payload byte index, 0 .. MAX_PAYLOAD-1
//   segment_num  header field, big-endian
//   txid, aux    header fields
//   hdr_valid    one-cycle pulse when the header fields update
//   frame_ok     one-cycle pulse at end of a good frame
//   frame_bad    one-cycle pulse at end of a failed frame
//   ok_count     good frames, saturating
//   bad_count    bad frames, saturating
// -----------------------------------------------------------------------------
module rx_frame_parser #(
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned MAX_PAYLOAD = 1440,
  parameter logic [47:0] MY_MAC      = 48'h00_0A_35_02_AF_9A
) (
  input  logic             clk125MHz,
  input  logic             rstb,
  rx_frame_parser_if.slave rx,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic [12:0]      out_addr,
  output logic [15:0]      segment_num,
  output logic [7:0]       txid,
  output logic [7:0]       aux,
  output logic             hdr_valid,
  output logic             frame_ok,
  output logic             frame_bad,
  output logic [15:0]      ok_count,
  output logic [15:0]      bad_count
);

  typedef enum logic [2:0] {WAIT_IDLE, HUNT, PRE, HDR, PAY, DROP, END} state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q;
  logic [31:0] crc_rev;
  logic [4:0]  hdr_cnt_q;
  logic [7:0]  et_hi_q, seg_hi_q, seg_lo_q, txid_q;
  logic [7:0]  dl_q [4];          // dl_q[3] is the oldest byte
  logic [2:0]  fill_q;
  logic [12:0] emit_cnt_q;
  logic        silent_q;

  logic accept;
  logic crc_clr, crc_en, emit, hdr_done, mac_reject, end_ok, end_bad;

  assign accept = rx.in_valid && rx.in_enable;

  // The residue constant is in normal bit order; the register is reflected.
  assign crc_rev = {<<{crc_q}};

`ifdef MAC_FILTER_EN
  logic [47:0] dst_q;
  logic [47:0] dst_now;
  assign dst_now = {dst_q[39:0], rx.in_data};
`else
  logic unused_my_mac;
  assign unused_my_mac = ^MY_MAC;
`endif

  // Reflected IEEE 802.3 CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction

  always_ff @(posedge clk125MHz or negedge rstb) begin
    if (!rstb) state_q <= WAIT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    emit       = 1'b0;
    hdr_done   = 1'b0;
    mac_reject = 1'b0;
    end_ok     = 1'b0;
    end_bad    = 1'b0;
    unique case (state_q)
      // Never lock onto a frame already running when reset was released.
      WAIT_IDLE: if (!rx.in_valid) state_d = HUNT;
      HUNT:      if (accept && rx.in_data == 8'h55) state_d = PRE;
      PRE: begin
        if (!rx.in_valid) state_d = HUNT;
        else if (accept) begin
          if (rx.in_data == 8'hD5) begin
            state_d = HDR;
            crc_clr = 1'b1;
          end else if (rx.in_data != 8'h55) begin
            state_d = DROP;
          end
        end
      end
      HDR: begin
        if (!rx.in_valid) begin
          state_d = END;
          end_bad = 1'b1;
        end else if (accept) begin
          crc_en = 1'b1;
          if (rx.in_error) state_d = DROP;
`ifdef MAC_FILTER_EN
          else if (hdr_cnt_q == 5'd5 && dst_now != MY_MAC && dst_now != 48'hFFFF_FFFF_FFFF) begin
            state_d    = DROP;
            mac_reject = 1'b1;
          end
`endif
          else if (hdr_cnt_q == 5'd13 && {et_hi_q, rx.in_data} != ETHERTYPE) state_d = DROP;
          else if (hdr_cnt_q == 5'd17) begin
            state_d  = PAY;
            hdr_done = 1'b1;
          end
        end
      end
      PAY: begin
        if (!rx.in_valid) begin
          state_d = END;
          // At least one emitted byte implies the line also held a full FCS.
          if (emit_cnt_q != 13'd0 && crc_rev == 32'hC704_DD7B) end_ok = 1'b1;
          else                                                 end_bad = 1'b1;
        end else if (accept) begin
          crc_en = 1'b1;
          if (rx.in_error) state_d = DROP;
          else if (fill_q == 3'd4) begin
            if (emit_cnt_q == 13'(MAX_PAYLOAD)) state_d = DROP;
            else                                emit    = 1'b1;
          end
        end
      end
      DROP: begin
        if (!rx.in_valid) begin
          state_d = END;
          end_bad = !silent_q;
        end
      end
      END:     state_d = HUNT;
      default: state_d = WAIT_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk125MHz or negedge rstb) begin
    if (!rstb) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      segment_num <= '0;
      txid        <= '0;
      aux         <= '0;
      hdr_valid   <= 1'b0;
      frame_ok    <= 1'b0;
      frame_bad   <= 1'b0;
      ok_count    <= '0;
      bad_count   <= '0;
      crc_q       <= '1;
      hdr_cnt_q   <= '0;
      et_hi_q     <= '0;
      seg_hi_q    <= '0;
      seg_lo_q    <= '0;
      txid_q      <= '0;
      fill_q      <= '0;
      emit_cnt_q  <= '0;
      silent_q    <= 1'b0;
      // NOTE: the delay line is small and must come out of reset empty, so
      // it is reset explicitly rather than left as an unreset memory.
      for (int i = 0; i < 4; i++) dl_q[i] <= '0;
`ifdef MAC_FILTER_EN
      dst_q       <= '0;
`endif
    end else begin
      out_valid <= emit;
      hdr_valid <= hdr_done;
      frame_ok  <= end_ok;
      frame_bad <= end_bad;
      if (end_ok  && ok_count  != 16'hFFFF) ok_count  <= ok_count  + 16'd1;
      if (end_bad && bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;

      if (crc_clr)     crc_q <= '1;
      else if (crc_en) crc_q <= crc_next(crc_q, rx.in_data);

      if (crc_clr) begin
        hdr_cnt_q  <= '0;
        fill_q     <= '0;
        emit_cnt_q <= '0;
      end

      if (state_q == HDR && accept) begin
        hdr_cnt_q <= hdr_cnt_q + 5'd1;
        case (hdr_cnt_q)
          5'd12:   et_hi_q  <= rx.in_data;
          5'd14:   seg_hi_q <= rx.in_data;
          5'd15:   seg_lo_q <= rx.in_data;
          5'd16:   txid_q   <= rx.in_data;
          default: ;
        endcase
`ifdef MAC_FILTER_EN
        if (hdr_cnt_q < 5'd6) dst_q <= dst_now;
`endif
      end

      if (hdr_done) begin
        segment_num <= {seg_hi_q, seg_lo_q};
        txid        <= txid_q;
        aux         <= rx.in_data;
      end

      if (state_q == PAY && accept) begin
        dl_q[3] <= dl_q[2];
        dl_q[2] <= dl_q[1];
        dl_q[1] <= dl_q[0];
        dl_q[0] <= rx.in_data;
        if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
      end

      if (emit) begin
        out_data   <= dl_q[3];
        out_addr   <= emit_cnt_q;
        emit_cnt_q <= emit_cnt_q + 13'd1;
      end

      if (mac_reject)          silent_q <= 1'b1;
      else if (state_q == END) silent_q <= 1'b0;
    end
  end

endmodule
